// File: rtl/led_effect_scheduler.sv
// Steps a 7-LED bar through bounce, fill and blink effects at a prescaled rate.
// Effects advance automatically after a set number of steps or on a button pulse.
module led_effect_scheduler #(
   parameter int unsigned CLK_DIV        = 5_000_000,
   parameter int unsigned STEPS_PER_MODE = 14
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       switch,
   input  logic       auto_en,
   input  logic       next_btn,
   output logic [6:0] leds,
   output logic [1:0] mode,
   output logic       step_tick
);

   localparam int unsigned DIV_W  = $clog2(CLK_DIV);
   localparam int unsigned STEP_W = $clog2(STEPS_PER_MODE + 1);
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEPS_PER_MODE - 1);

   localparam logic [6:0] PAT_FIRST = 7'b0000001;
   localparam logic [6:0] PAT_BLINK = 7'b1010101;
   localparam logic [6:0] PAT_FULL  = 7'b1111111;

   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_BOUNCE = 2'b01,
      ST_FILL   = 2'b10,
      ST_BLINK  = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          leds_q, leds_d;
   logic                step_tick_q, step_tick_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic [2:0]          pos_q, pos_d;
   logic                dir_q, dir_d;
   logic                advance;
   logic [2:0]          pos_nxt;

   // State register and datapath flops.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state_q     <= ST_OFF;
         leds_q      <= 7'd0;
         step_tick_q <= 1'b0;
         div_cnt_q   <= '0;
         step_cnt_q  <= '0;
         pos_q       <= 3'd0;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         leds_q      <= leds_d;
         step_tick_q <= step_tick_d;
         div_cnt_q   <= div_cnt_d;
         step_cnt_q  <= step_cnt_d;
         pos_q       <= pos_d;
         dir_q       <= dir_d;
      end
   end

   // Next-state, effect sequencing and prescaler.
   always_comb begin
      state_d    = state_q;
      leds_d     = leds_q;
      div_cnt_d  = div_cnt_q;
      step_cnt_d = step_cnt_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      advance    = 1'b0;
      pos_nxt    = dir_q ? (pos_q - 3'd1) : (pos_q + 3'd1);

      if (!switch) begin
         state_d    = ST_OFF;
         leds_d     = 7'd0;
         div_cnt_d  = '0;
         step_cnt_d = '0;
         pos_d      = 3'd0;
         dir_d      = 1'b0;
      end else if (state_q == ST_OFF) begin
         state_d    = ST_BOUNCE;
         leds_d     = PAT_FIRST;
         div_cnt_d  = '0;
         step_cnt_d = '0;
         pos_d      = 3'd0;
         dir_d      = 1'b0;
      end else begin
         // A button and an auto-advance in the same cycle still move one mode.
         advance = next_btn || (step_tick_q && auto_en && (step_cnt_q == STEP_MAX));
         if (advance) begin
            div_cnt_d  = '0;
            step_cnt_d = '0;
            pos_d      = 3'd0;
            dir_d      = 1'b0;
            unique case (state_q)
               ST_BOUNCE: begin
                  state_d = ST_FILL;
                  leds_d  = PAT_FIRST;
               end
               ST_FILL: begin
                  state_d = ST_BLINK;
                  leds_d  = PAT_BLINK;
               end
               default: begin
                  state_d = ST_BOUNCE;
                  leds_d  = PAT_FIRST;
               end
            endcase
         end else if (step_tick_q) begin
            div_cnt_d  = '0;
            step_cnt_d = (step_cnt_q == STEP_MAX) ? step_cnt_q : (step_cnt_q + STEP_W'(1));
            unique case (state_q)
               ST_BOUNCE: begin
                  pos_d  = pos_nxt;
                  leds_d = 7'd1 << pos_nxt;
                  if (pos_nxt == 3'd6) begin
                     dir_d = 1'b1;
                  end else if (pos_nxt == 3'd0) begin
                     dir_d = 1'b0;
                  end
               end
               ST_FILL: begin
                  leds_d = (leds_q == PAT_FULL) ? 7'd0 : {leds_q[5:0], 1'b1};
               end
               default: begin
                  leds_d = ~leds_q;
               end
            endcase
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end

      // Registered strobe is high exactly while the prescaler sits at its last count.
      step_tick_d = switch && (div_cnt_d == DIV_MAX);
   end

   assign leds      = leds_q;
   assign mode      = state_q;
   assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_effect_scheduler.sv
// Randomized and directed stimulus for led_effect_scheduler, checked per cycle
// against an effect-level reference model through a scoreboard queue.
module tb_led_effect_scheduler;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned STEPS   = 14;

   logic       clk_50M = 1'b0;
   logic       rst_n   = 1'b0;
   logic       switch  = 1'b0;
   logic       auto_en = 1'b0;
   logic       next_btn = 1'b0;
   logic [6:0] leds;
   logic [1:0] mode;
   logic       step_tick;

   typedef struct packed {
      logic [1:0] mode;
      logic [6:0] leds;
      logic       tick;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Model state: current effect, ticks taken in it, cycles since prescaler restart.
   int   m_mode = 0;
   int   m_n    = 0;
   int   m_ph   = 0;

   led_effect_scheduler #(
      .CLK_DIV(CLK_DIV),
      .STEPS_PER_MODE(STEPS)
   ) dut (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .switch   (switch),
      .auto_en  (auto_en),
      .next_btn (next_btn),
      .leds     (leds),
      .mode     (mode),
      .step_tick(step_tick)
   );

   always #5 clk_50M = ~clk_50M;

   function automatic logic [6:0] exp_leds(input int md, input int n);
      int p;
      int k;
      logic [7:0] w;
      case (md)
         1: begin
            p = n % 12;
            if (p > 6) p = 12 - p;
            w = 8'd1 << p;
            return w[6:0];
         end
         2: begin
            k = (n + 1) % 8;
            w = (8'd1 << k) - 8'd1;
            return w[6:0];
         end
         3: return (n % 2 == 0) ? 7'h55 : 7'h2A;
         default: return 7'h00;
      endcase
   endfunction

   function automatic int sat_steps(input int n);
      return (n < int'(STEPS) - 1) ? n : int'(STEPS) - 1;
   endfunction

   // Reference model: advance at every edge and queue the expected outputs.
   always @(posedge clk_50M) begin
      exp_t e;
      bit tick;
      bit adv;
      if (!rst_n || !switch) begin
         m_mode = 0;
         m_n    = 0;
         m_ph   = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
         m_n    = 0;
         m_ph   = 0;
      end else begin
         tick = (m_ph == int'(CLK_DIV) - 1);
         adv  = next_btn || (tick && auto_en && sat_steps(m_n) == int'(STEPS) - 1);
         if (adv) begin
            m_mode = (m_mode == 3) ? 1 : m_mode + 1;
            m_n    = 0;
            m_ph   = 0;
         end else begin
            m_ph = (m_ph + 1) % int'(CLK_DIV);
            if (tick) m_n = m_n + 1;
         end
      end
      e.mode = 2'(m_mode);
      e.leds = exp_leds(m_mode, m_n);
      e.tick = (m_mode != 0) && (m_ph == int'(CLK_DIV) - 1);
      exp_q.push_back(e);
   end

   // Monitor: pop one expectation per cycle and compare away from the active edge.
   always @(negedge clk_50M) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (mode !== e.mode || leds !== e.leds || step_tick !== e.tick) begin
            bad++;
            $display("FAIL outputs t=%0t: mode=%b leds=%b tick=%b, expected mode=%b leds=%b tick=%b",
                     $time, mode, leds, step_tick, e.mode, e.leds, e.tick);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   // Wait until the next edge is an auto-advance tick, bounded.
   task automatic wait_auto_edge(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (m_mode != 0 && auto_en && m_ph == int'(CLK_DIV) - 1 &&
             sat_steps(m_n) == int'(STEPS) - 1) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   initial begin
      bit ok;
      cyc(2);
      rst_n = 1'b1;
      cyc(20);

      // Bounce walk with saturation, no auto-advance.
      switch = 1'b1;
      cyc(70);

      // Auto-advance through all effects from a fresh bounce entry.
      switch = 1'b0;
      cyc(1);
      switch  = 1'b1;
      auto_en = 1'b1;
      cyc(CLK_DIV * STEPS * 2 + 20);

      // Button mid-step in blink.
      while (m_ph != 1) cyc(1);
      next_btn = 1'b1;
      cyc(1);
      next_btn = 1'b0;
      cyc(10);

      // Button coincident with an auto-advance tick.
      wait_auto_edge(300, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL coincident_wait: no auto-advance edge within budget, expected one");
      end
      next_btn = 1'b1;
      cyc(1);
      next_btn = 1'b0;
      cyc(20);

      // Drop switch mid-fill, then re-raise.
      auto_en = 1'b0;
      for (int i = 0; i < 300 && m_mode != 2; i++) begin
         next_btn = (m_mode != 2) && (i % 3 == 0);
         cyc(1);
      end
      next_btn = 1'b0;
      cyc(9);
      switch = 1'b0;
      cyc(3);
      switch = 1'b1;
      cyc(15);

      // One-cycle reset mid-bounce with switch held high.
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(12);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         next_btn = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 199) == 0) switch = ~switch;
         else if (!switch && $urandom_range(0, 9) == 0) switch = 1'b1;
         rst_n = ($urandom_range(0, 499) != 0);
         cyc(1);
      end
      rst_n    = 1'b1;
      next_btn = 1'b0;
      cyc(2);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
